// File: rtl/sap_ram_controller.sv
// Sequencer/arbiter for the SAP 16-word RAM (two SN74189 chips side by side).
// Shares the RAM between loader, CPU reads and an init sweep; makes S_bar/W_bar strobes with setup/hold.
module sap_ram_controller #(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 4,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              CLK,
  input  logic              CLR_bar,
  input  logic              prog,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              init_req,
  output logic              init_busy,
  output logic [ADDR_W-1:0] ram_A,
  output logic [DATA_W-1:0] ram_DI,
  input  logic [DATA_W-1:0] ram_DO,
  output logic              ram_S_bar,
  output logic              ram_W_bar
);

  typedef enum logic [2:0] {
    IDLE, RD_SEL, RD_ACK, WR_SETUP, WR_PULSE, WR_HOLD
  } state_e;

  state_e              state_q, state_d;
  logic                own_cpu_q, own_cpu_d;
  logic                init_q, init_d;
  logic                init_pend_q, init_pend_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   di_q, di_d;
  logic [DATA_W-1:0]   ld_rdata_q, ld_rdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   ram_true;

  // Each SN74189 drives its nibble complemented; undo it per chip.
  generate
    for (genvar gi = 0; gi < DATA_W / 4; gi++) begin : g_nibble
      assign ram_true[gi*4 +: 4] = ~ram_DO[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      state_q     <= IDLE;
      own_cpu_q   <= 1'b0;
      init_q      <= 1'b0;
      init_pend_q <= 1'b0;
      addr_q      <= '0;
      di_q        <= '0;
      ld_rdata_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      own_cpu_q   <= own_cpu_d;
      init_q      <= init_d;
      init_pend_q <= init_pend_d;
      addr_q      <= addr_d;
      di_q        <= di_d;
      ld_rdata_q  <= ld_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    own_cpu_d   = own_cpu_q;
    init_d      = init_q;
    init_pend_d = init_pend_q | (init_req & ~init_q);
    addr_d      = addr_q;
    di_d        = di_q;
    ld_rdata_d  = ld_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
    unique case (state_q)
      IDLE: begin
        // A same-edge init_req counts as pending so it beats a simultaneous request.
        if (init_pend_q || init_req) begin
          init_d      = 1'b1;
          init_pend_d = 1'b0;
          addr_d      = '0;
          di_d        = INIT_VALUE;
          state_d     = WR_SETUP;
        end else if (prog && ld_req) begin
          own_cpu_d = 1'b0;
          addr_d    = ld_addr;
          di_d      = ld_we ? ld_wdata : '0;
          state_d   = ld_we ? WR_SETUP : RD_SEL;
        end else if (!prog && cpu_req) begin
          own_cpu_d = 1'b1;
          addr_d    = cpu_addr;
          di_d      = '0;
          state_d   = RD_SEL;
        end
      end
      RD_SEL: begin
        if (own_cpu_q) cpu_rdata_d = ram_true;
        else           ld_rdata_d  = ram_true;
        state_d = RD_ACK;
      end
      RD_ACK:   state_d = IDLE;
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: state_d = WR_HOLD;
      WR_HOLD: begin
        if (init_q && (addr_q != '1)) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = WR_SETUP;
        end else begin
          init_d  = 1'b0;
          addr_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from the async-reset state so reset releases them at once.
  always_comb begin
    ram_S_bar = 1'b1;
    ram_W_bar = 1'b1;
    ram_A     = '0;
    ram_DI    = '0;
    ld_ack    = 1'b0;
    cpu_ack   = 1'b0;
    unique case (state_q)
      RD_SEL: begin
        ram_S_bar = 1'b0;
        ram_A     = addr_q;
      end
      RD_ACK: begin
        ram_A   = addr_q;
        ld_ack  = ~own_cpu_q;
        cpu_ack = own_cpu_q;
      end
      WR_SETUP: begin
        ram_S_bar = 1'b0;
        ram_A     = addr_q;
        ram_DI    = di_q;
      end
      WR_PULSE: begin
        ram_S_bar = 1'b0;
        ram_W_bar = 1'b0;
        ram_A     = addr_q;
        ram_DI    = di_q;
      end
      WR_HOLD: begin
        ram_S_bar = 1'b0;
        ram_A     = addr_q;
        ram_DI    = di_q;
        ld_ack    = ~init_q;
      end
      default: ;
    endcase
  end

  assign init_busy = init_q;
  assign ld_rdata  = ld_rdata_q;
  assign cpu_rdata = cpu_rdata_q;

endmodule
